// File: rtl/ysyx_axi4_pkg.sv
// Shared AXI4 definitions: burst/response codes, FSM encodings and the
// per-beat address advance used by every AXI block in this tree.
package ysyx_axi4_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Callers truncate the 64-bit result to their own address width, which
  // gives natural wrap-around at the top of the address space.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input axi_burst_t  burst);
    return (burst == BURST_INCR) ? addr + (64'd1 << size) : addr;
  endfunction

endpackage

// File: rtl/ysyx_axi4_mem_slave_if.sv
// AXI4 bus between the core's arbiter (master) and the memory model (slave).
interface ysyx_axi4_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [1:0]        arburst;
  logic [2:0]        arsize;
  logic [7:0]        arlen;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [1:0]        awburst;
  logic [2:0]        awsize;
  logic [7:0]        awlen;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;

  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arburst, arsize, arlen, arid, araddr, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awburst, awsize, awlen, awid, awaddr, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arburst, arsize, arlen, arid, araddr, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awburst, awsize, awlen, awid, awaddr, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/ysyx_axi4_mem_array.sv
// Word-organised memory: one synchronous read port, one byte-enabled
// synchronous write port; a same-cycle read of the written word sees old data.
module ysyx_axi4_mem_array #(
  parameter int MEM_AW = 12,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [MEM_AW-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [MEM_AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb
);

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: neither mem nor rd_data_q is reset: a resettable array cannot map to
  // block RAM, and memory contents must survive a bus reset.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ysyx_axi4_mem_slave.sv
// AXI4 main-memory model: independent read and write FSMs, one outstanding
// transaction each, configurable read latency, SLVERR on bad address or burst.
module ysyx_axi4_mem_slave
  import ysyx_axi4_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 64,
  parameter int                ID_W     = 4,
  parameter int                MEM_AW   = 12,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter int                RD_LAT   = 2
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_axi4_mem_slave_if.slave bus
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(1) << (MEM_AW + 3);

  function automatic logic beat_ok(input logic [ADDR_W-1:0] a, input axi_burst_t b);
    logic [ADDR_W-1:0] off;
    off = a - MEM_BASE;
    return (a >= MEM_BASE) && ({1'b0, off} < MEM_BYTES) &&
           ((b == BURST_FIXED) || (b == BURST_INCR));
  endfunction

  // Read channel state
  logic [1:0]        r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_next;
  logic [2:0]        r_size_q, r_size_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  axi_burst_t        r_burst_q, r_burst_d;
  logic [LAT_W-1:0]  r_wait_q, r_wait_d;
  logic              rvalid_q, rvalid_d;
  axi_resp_t         rresp_q, rresp_d;
  logic              rdata_ok_q, rdata_ok_d;

  // Write channel state
  logic [1:0]        w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d, w_next;
  logic [2:0]        w_size_q, w_size_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  axi_burst_t        w_burst_q, w_burst_d;
  logic              w_err_q, w_err_d;
  logic              bvalid_q, bvalid_d;
  axi_resp_t         bresp_q, bresp_d;
  logic              w_beat_ok;

  logic                rd_en, wr_en;
  logic [MEM_AW-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_data;

  assign r_next    = ADDR_W'(axi_next_addr(64'(r_addr_q), r_size_q, r_burst_q));
  assign w_next    = ADDR_W'(axi_next_addr(64'(w_addr_q), w_size_q, w_burst_q));
  assign w_beat_ok = beat_ok(w_addr_q, w_burst_q);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_addr_d   = r_addr_q;
    r_size_d   = r_size_q;
    r_cnt_d    = r_cnt_q;
    r_burst_d  = r_burst_q;
    r_wait_d   = r_wait_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_ok_d = rdata_ok_q;
    rd_en      = 1'b0;
    rd_word    = r_addr_q[MEM_AW+2:3];
    case (r_state_q)
      R_IDLE: if (bus.arvalid) begin
        r_id_d    = bus.arid;
        r_addr_d  = bus.araddr;
        r_size_d  = bus.arsize;
        r_cnt_d   = bus.arlen;
        r_burst_d = bus.arburst;
        r_wait_d  = LAT_W'(RD_LAT - 1);
        r_state_d = R_WAIT;
      end
      R_WAIT: if (r_wait_q == '0) begin
        rd_en      = 1'b1;
        rdata_ok_d = beat_ok(r_addr_q, r_burst_q);
        rresp_d    = rdata_ok_d ? RESP_OKAY : RESP_SLVERR;
        rvalid_d   = 1'b1;
        r_state_d  = R_DATA;
      end else begin
        r_wait_d = r_wait_q - 1'b1;
      end
      R_DATA: if (bus.rready) begin
        if (r_cnt_q == 8'd0) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_addr_d   = r_next;
          r_cnt_d    = r_cnt_q - 8'd1;
          rd_en      = 1'b1;
          rd_word    = r_next[MEM_AW+2:3];
          rdata_ok_d = beat_ok(r_next, r_burst_q);
          rresp_d    = rdata_ok_d ? RESP_OKAY : RESP_SLVERR;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_size_d  = w_size_q;
    w_cnt_d   = w_cnt_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    case (w_state_q)
      W_IDLE: if (bus.awvalid) begin
        w_id_d    = bus.awid;
        w_addr_d  = bus.awaddr;
        w_size_d  = bus.awsize;
        w_cnt_d   = bus.awlen;
        w_burst_d = bus.awburst;
        w_err_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (bus.wvalid) begin
        wr_en   = w_beat_ok;
        // A wlast that disagrees with the beat count is an error, but the
        // burst length is still governed by the count alone.
        w_err_d = w_err_q | ~w_beat_ok | (bus.wlast != (w_cnt_q == 8'd0));
        if (w_cnt_q == 8'd0) begin
          bvalid_d  = 1'b1;
          bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          w_addr_d = w_next;
          w_cnt_d  = w_cnt_q - 8'd1;
        end
      end
      W_RESP: if (bus.bready) begin
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q  <= R_IDLE;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_size_q   <= '0;
      r_cnt_q    <= '0;
      r_burst_q  <= BURST_FIXED;
      r_wait_q   <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_ok_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_id_q     <= r_id_d;
      r_addr_q   <= r_addr_d;
      r_size_q   <= r_size_d;
      r_cnt_q    <= r_cnt_d;
      r_burst_q  <= r_burst_d;
      r_wait_q   <= r_wait_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_ok_q <= rdata_ok_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= BURST_FIXED;
      w_err_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_size_q  <= w_size_d;
      w_cnt_q   <= w_cnt_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  ysyx_axi4_mem_array #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_word),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (w_addr_q[MEM_AW+2:3]),
    .wr_data (bus.wdata),
    .wr_strb (bus.wstrb)
  );

  // The RAM output register is not reset, so error beats and the reset
  // state are forced to zero here.
  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rvalid_q && (r_cnt_q == 8'd0);
  assign bus.rdata   = rdata_ok_q ? rd_data : '0;
  assign bus.rresp   = rresp_q;
  assign bus.rid     = r_id_q;

  assign bus.awready = (w_state_q == W_IDLE);
  assign bus.wready  = (w_state_q == W_DATA);
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = w_id_q;

endmodule
